centroid_track_ctrl: RTL and testbench

Per-frame tracking controller that sequences centroid results from the colour-detection pipeline into a stable tracked coordinate pair for the downstream pan/tilt and overlay logic. Per frame it captures at most one centroid and validates it against frame bounds and a jump gate. A three-state acquire/track/lost machine decides whether the published coordinates follow the centroid, hold, or return to screen centre (320, 240).

---
 rtl/track_pkg.sv | 13 +
 rtl/coord_gate.sv | 28 ++
 rtl/centroid_track_ctrl.sv | 176 +++++++++++++++++
 tb/tb_centroid_track_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared types and constants for the centroid tracking controller.
package track_pkg;
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } track_state_t;

  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int DEF_CENTER_X = 320;
  localparam int DEF_CENTER_Y = 240;
endpackage

// File: rtl/coord_gate.sv
// Combinational frame-bounds and per-axis jump check of a captured centroid against a reference.
module coord_gate
  import track_pkg::*;
#(
  parameter int MAX_JUMP = 64
) (
  input  logic       i_cap_v,
  input  logic [9:0] i_cap_x,
  input  logic [8:0] i_cap_y,
  input  logic [9:0] i_ref_x,
  input  logic [8:0] i_ref_y,
  output logic       o_valid,
  output logic       o_near
);
  logic signed [10:0] w_dx;
  logic signed [9:0]  w_dy;
  logic [10:0]        w_adx;
  logic [9:0]         w_ady;

  // One extra bit so the difference cannot overflow before the abs.
  assign w_dx  = $signed({1'b0, i_cap_x}) - $signed({1'b0, i_ref_x});
  assign w_dy  = $signed({1'b0, i_cap_y}) - $signed({1'b0, i_ref_y});
  assign w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
  assign w_ady = w_dy[9]  ? 10'(-w_dy) : 10'(w_dy);

  assign o_valid = i_cap_v && (i_cap_x < 10'(FRAME_W)) && (i_cap_y < 9'(FRAME_H));
  assign o_near  = (w_adx <= 11'(MAX_JUMP)) && (w_ady <= 10'(MAX_JUMP));
endmodule

// File: rtl/centroid_track_ctrl.sv
// Per-frame acquire/track/lost controller turning raw centroids into stable tracked coordinates.
module centroid_track_ctrl
  import track_pkg::*;
#(
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 15,
  parameter int MAX_JUMP    = 64,
  parameter int CENTER_X    = DEF_CENTER_X,
  parameter int CENTER_Y    = DEF_CENTER_Y
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_end,
  input  logic       cent_val,
  input  logic [9:0] cent_x,
  input  logic [8:0] cent_y,
  output logic [9:0] coord_x,
  output logic [8:0] coord_y,
  output logic       coord_upd,
  output logic       locked,
  output logic [1:0] state
);
  localparam logic [3:0] ACQ_T  = 4'(ACQ_FRAMES);
  localparam logic [7:0] LOST_T = 8'(LOST_FRAMES);
  localparam logic [9:0] CX     = 10'(CENTER_X);
  localparam logic [8:0] CY     = 9'(CENTER_Y);

  track_state_t r_state, w_nxt_state;
  logic       r_cap_v;
  logic [9:0] r_cap_x, r_cand_x, r_x, w_nxt_cand_x, w_nxt_x;
  logic [8:0] r_cap_y, r_cand_y, r_y, w_nxt_cand_y, w_nxt_y;
  logic [3:0] r_acq, w_nxt_acq, w_acq_inc;
  logic [7:0] r_miss, w_nxt_miss, w_miss_inc;
  logic       r_upd, w_nxt_upd;

  logic       w_cap_v;
  logic [9:0] w_cap_x, w_ref_x;
  logic [8:0] w_cap_y, w_ref_y;
  logic       w_valid, w_near, w_hit;

  // A centroid arriving with frame_end still belongs to the ending frame.
  assign w_cap_v = r_cap_v | cent_val;
  assign w_cap_x = r_cap_v ? r_cap_x : cent_x;
  assign w_cap_y = r_cap_v ? r_cap_y : cent_y;
  assign w_ref_x = (r_state == TRACK) ? r_x : r_cand_x;
  assign w_ref_y = (r_state == TRACK) ? r_y : r_cand_y;

  coord_gate #(.MAX_JUMP(MAX_JUMP)) u_gate (
    .i_cap_v (w_cap_v),
    .i_cap_x (w_cap_x),
    .i_cap_y (w_cap_y),
    .i_ref_x (w_ref_x),
    .i_ref_y (w_ref_y),
    .o_valid (w_valid),
    .o_near  (w_near)
  );

  assign w_hit      = w_valid && w_near;
  assign w_acq_inc  = (r_acq  == 4'hF)  ? r_acq  : r_acq + 4'd1;
  assign w_miss_inc = (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_v <= 1'b0;
      r_cap_x <= '0;
      r_cap_y <= '0;
    end else if (frame_end) begin
      r_cap_v <= 1'b0;
    end else if (cent_val && !r_cap_v) begin
      r_cap_v <= 1'b1;
      r_cap_x <= cent_x;
      r_cap_y <= cent_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SEARCH;
      r_acq    <= '0;
      r_miss   <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      r_x      <= CX;
      r_y      <= CY;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (frame_end) begin
        r_state  <= w_nxt_state;
        r_acq    <= w_nxt_acq;
        r_miss   <= w_nxt_miss;
        r_cand_x <= w_nxt_cand_x;
        r_cand_y <= w_nxt_cand_y;
        r_x      <= w_nxt_x;
        r_y      <= w_nxt_y;
        r_upd    <= w_nxt_upd;
      end
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_acq    = r_acq;
    w_nxt_miss   = r_miss;
    w_nxt_cand_x = r_cand_x;
    w_nxt_cand_y = r_cand_y;
    w_nxt_x      = r_x;
    w_nxt_y      = r_y;
    w_nxt_upd    = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (w_valid) begin
          w_nxt_cand_x = w_cap_x;
          w_nxt_cand_y = w_cap_y;
          w_nxt_acq    = 4'd1;
          if (ACQ_T <= 4'd1) begin
            w_nxt_state = TRACK;
            w_nxt_x     = w_cap_x;
            w_nxt_y     = w_cap_y;
            w_nxt_upd   = 1'b1;
            w_nxt_miss  = '0;
          end else begin
            w_nxt_state = ACQUIRE;
          end
        end
      end
      ACQUIRE: begin
        if (w_hit) begin
          w_nxt_cand_x = w_cap_x;
          w_nxt_cand_y = w_cap_y;
          w_nxt_acq    = w_acq_inc;
          if (w_acq_inc >= ACQ_T) begin
            w_nxt_state = TRACK;
            w_nxt_x     = w_cap_x;
            w_nxt_y     = w_cap_y;
            w_nxt_upd   = 1'b1;
            w_nxt_miss  = '0;
          end
        end else begin
          w_nxt_state = SEARCH;
          w_nxt_acq   = '0;
        end
      end
      TRACK: begin
        if (w_hit) begin
          w_nxt_x    = w_cap_x;
          w_nxt_y    = w_cap_y;
          w_nxt_upd  = 1'b1;
          w_nxt_miss = '0;
        end else if (w_miss_inc >= LOST_T) begin
          w_nxt_state = SEARCH;
          w_nxt_x     = CX;
          w_nxt_y     = CY;
          w_nxt_upd   = 1'b1;
          w_nxt_miss  = '0;
          w_nxt_acq   = '0;
        end else begin
          w_nxt_miss = w_miss_inc;
        end
      end
      default: begin
        w_nxt_state = SEARCH;
        w_nxt_acq   = '0;
        w_nxt_miss  = '0;
        w_nxt_x     = CX;
        w_nxt_y     = CY;
      end
    endcase
  end

  assign coord_x   = r_x;
  assign coord_y   = r_y;
  assign coord_upd = r_upd;
  assign locked    = (r_state == TRACK);
  assign state     = r_state;
endmodule

// File: tb/tb_centroid_track_ctrl.sv
// Directed-vector bench for centroid_track_ctrl with hand-computed expectations.
module tb_centroid_track_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_end = 1'b0;
  logic       cent_val = 1'b0;
  logic [9:0] cent_x = '0;
  logic [8:0] cent_y = '0;
  logic [9:0] coord_x;
  logic [8:0] coord_y;
  logic       coord_upd, locked;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  centroid_track_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .cent_val  (cent_val),
    .cent_x    (cent_x),
    .cent_y    (cent_y),
    .coord_x   (coord_x),
    .coord_y   (coord_y),
    .coord_upd (coord_upd),
    .locked    (locked),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit hv, input int x, input int y);
    if (hv) begin
      cent_val = 1'b1;
      cent_x   = 10'(x);
      cent_y   = 9'(y);
      tick();
      cent_val = 1'b0;
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int s, input int x, input int y, input int upd);
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".x"}, int'(coord_x), x);
    chk({tag, ".y"}, int'(coord_y), y);
    chk({tag, ".upd"}, int'(coord_upd), upd);
    chk({tag, ".locked"}, int'(locked), (s == 2) ? 1 : 0);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_out("reset", 0, 320, 240, 0);

    for (int i = 0; i < 5; i++) frame(1'b0, 0, 0);
    chk_out("empty5", 0, 320, 240, 0);

    frame(1'b1, 100, 50);
    chk_out("acq1", 1, 320, 240, 0);
    frame(1'b1, 100, 50);
    chk_out("acq2", 1, 320, 240, 0);
    frame(1'b1, 100, 50);
    chk_out("acq3", 2, 100, 50, 1);
    tick();
    chk("acq3.upd_drop", int'(coord_upd), 0);

    frame(1'b1, 200, 50);
    chk_out("far", 2, 100, 50, 0);
    frame(1'b1, 150, 90);
    chk_out("near", 2, 150, 90, 1);

    // first centroid of the frame wins
    cent_val = 1'b1; cent_x = 10'd120; cent_y = 9'd60; tick();
    cent_x = 10'd400; cent_y = 9'd300; tick();
    cent_val = 1'b0;
    frame(1'b0, 0, 0);
    chk_out("dual_a", 2, 120, 60, 1);

    // centroid coincident with frame_end counts for that frame
    cent_val = 1'b1; cent_x = 10'd130; cent_y = 9'd70; frame_end = 1'b1; tick();
    cent_val = 1'b0; frame_end = 1'b0;
    chk_out("coinc", 2, 130, 70, 1);

    cent_val = 1'b1; cent_x = 10'd400; cent_y = 9'd300; tick();
    cent_x = 10'd140; cent_y = 9'd80; tick();
    cent_val = 1'b0;
    frame(1'b0, 0, 0);
    chk_out("dual_b", 2, 130, 70, 0);

    frame(1'b1, 135, 75);
    chk_out("rehit", 2, 135, 75, 1);

    for (int i = 0; i < 14; i++) frame(1'b0, 0, 0);
    chk_out("miss14", 2, 135, 75, 0);
    frame(1'b0, 0, 0);
    chk_out("miss15", 0, 320, 240, 1);
    tick();
    chk("miss15.upd_drop", int'(coord_upd), 0);

    frame(1'b1, 700, 10);
    chk_out("oob_x", 0, 320, 240, 0);
    frame(1'b1, 10, 480);
    chk_out("oob_y", 0, 320, 240, 0);

    frame(1'b1, 100, 100);
    chk("acqfar1.state", int'(state), 1);
    frame(1'b1, 300, 100);
    chk_out("acqfar2", 0, 320, 240, 0);

    frame(1'b1, 100, 100);
    frame(1'b1, 110, 100);
    chk("pre_rst.state", int'(state), 1);
    cent_val = 1'b1; cent_x = 10'd110; cent_y = 9'd100; tick();
    cent_val = 1'b0;
    rst = 1'b1; frame_end = 1'b1; tick();
    frame_end = 1'b0;
    chk_out("mid_rst", 0, 320, 240, 0);
    rst = 1'b0;
    frame(1'b0, 0, 0);
    chk_out("post_rst", 0, 320, 240, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
